// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: scan state type and segment patterns.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

   typedef enum logic [0:0] {
      SHOW  = 1'b0,
      GUARD = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder.
// Non-decimal codes A..F render as a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   // Digit pattern lookup
   always_comb begin
      seg_o = SEG_DASH;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// Three-digit multiplexed seven-segment scanner with leading-zero blanking.
// Each digit is shown for PRESCALE cycles followed by one dark guard cycle.
module bcd_seg_scan
   import seg7_pkg::*;
#(
   parameter int PRESCALE = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] bcd_in,
   input  logic        load,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic [2:0]  an,
   output logic        frame_done
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

   scan_state_t      state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [11:0]      disp_q, disp_d;

   logic [3:0]       digit;
   logic [6:0]       digit_seg;
   logic             blank_digit;

   // Next-state logic for scan sequencer and display register
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      disp_d  = load ? bcd_in : disp_q;
      case (state_q)
         SHOW: begin
            if (cnt_q == CNT_LAST) begin
               state_d = GUARD;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         GUARD: begin
            state_d = SHOW;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
         end
         default: begin
            state_d = SHOW;
            idx_d   = 2'd0;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State registers; reset wins over a concurrent load
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SHOW;
         idx_q   <= 2'd0;
         cnt_q   <= {CNT_W{1'b0}};
         disp_q  <= 12'h000;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
      end
   end

   // Current digit and blanking; a dash code counts as non-zero
   always_comb begin
      digit       = 4'd0;
      blank_digit = 1'b0;
      case (idx_q)
         2'd0: begin
            digit       = disp_q[3:0];
            blank_digit = 1'b0;
         end
         2'd1: begin
            digit       = disp_q[7:4];
            blank_digit = blank_lz && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
         end
         2'd2: begin
            digit       = disp_q[11:8];
            blank_digit = blank_lz && (disp_q[11:8] == 4'd0);
         end
         default: begin
            digit       = 4'd0;
            blank_digit = 1'b1;
         end
      endcase
   end

   bcd_to_seg7 u_dec (
      .digit_i (digit),
      .seg_o   (digit_seg)
   );

   // Output decode from registered state only
   always_comb begin
      an         = 3'b000;
      seg        = SEG_BLANK;
      frame_done = 1'b0;
      if (state_q == SHOW) begin
         case (idx_q)
            2'd0:    an = 3'b001;
            2'd1:    an = 3'b010;
            2'd2:    an = 3'b100;
            default: an = 3'b000;
         endcase
         seg = blank_digit ? SEG_BLANK : digit_seg;
      end else begin
         frame_done = (idx_q == 2'd2);
      end
   end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed self-checking bench for bcd_seg_scan with PRESCALE=4.
module tb_bcd_seg_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] bcd_in;
   logic        load;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [2:0]  an;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   bcd_seg_scan #(.PRESCALE(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .bcd_in     (bcd_in),
      .load       (load),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [2:0] an_e, input logic [6:0] seg_e, input logic fd_e);
      #1;
      checks++;
      assert ({an, seg, frame_done} === {an_e, seg_e, fd_e})
      else begin
         errors++;
         $error("FAIL %s: observed an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
                tag, an, seg, frame_done, an_e, seg_e, fd_e);
      end
   endtask

   // One full 15-cycle frame from units SHOW; optional load on the final guard cycle
   task automatic frame_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input bit ld, input logic [11:0] v);
      logic [6:0] codes [3];
      logic [2:0] an_e;
      codes[0] = s0;
      codes[1] = s1;
      codes[2] = s2;
      for (int d = 0; d < 3; d++) begin
         an_e = 3'b001 << d;
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s show d%0d c%0d", tag, d, c), an_e, codes[d], 1'b0);
            tick();
         end
         if (d == 2 && ld) begin
            load   = 1'b1;
            bcd_in = v;
         end
         chk($sformatf("%s guard d%0d", tag, d), 3'b000, 7'h00, (d == 2));
         tick();
         load = 1'b0;
      end
   endtask

   initial begin
      rst      = 1'b1;
      load     = 1'b1;
      bcd_in   = 12'h255;
      blank_lz = 1'b0;
      tick();
      tick();
      rst  = 1'b0;
      load = 1'b0;

      // Reset state, and reset beat the concurrent load
      frame_check("reset0", 7'h3F, 7'h3F, 7'h3F, 1'b1, 12'h255);
      frame_check("ld255", 7'h6D, 7'h6D, 7'h5B, 1'b1, 12'h007);
      blank_lz = 1'b1;
      frame_check("lz007", 7'h07, 7'h00, 7'h00, 1'b1, 12'h102);
      frame_check("lz102", 7'h5B, 7'h3F, 7'h06, 1'b1, 12'h000);
      frame_check("lz000", 7'h3F, 7'h00, 7'h00, 1'b1, 12'h0A3);
      frame_check("lz0A3", 7'h4F, 7'h40, 7'h00, 1'b1, 12'hF0C);
      frame_check("lzF0C", 7'h40, 7'h3F, 7'h40, 1'b0, 12'h000);

      // Mid-phase loads during tens SHOW
      for (int c = 0; c < 4; c++) begin
         chk("midld units", 3'b001, 7'h40, 1'b0);
         tick();
      end
      chk("midld guard0", 3'b000, 7'h00, 1'b0);
      tick();
      chk("midld tens c1", 3'b010, 7'h3F, 1'b0);
      tick();
      load   = 1'b1;
      bcd_in = 12'h111;
      chk("midld tens c2", 3'b010, 7'h3F, 1'b0);
      tick();
      load = 1'b0;
      chk("midld tens c3", 3'b010, 7'h06, 1'b0);
      tick();
      load   = 1'b1;
      bcd_in = 12'h999;
      chk("midld tens c4", 3'b010, 7'h06, 1'b0);
      tick();
      load = 1'b0;
      chk("midld guard1", 3'b000, 7'h00, 1'b0);
      tick();
      for (int c = 0; c < 4; c++) begin
         chk("midld hund", 3'b100, 7'h6F, 1'b0);
         tick();
      end
      chk("midld guard2", 3'b000, 7'h00, 1'b1);
      tick();
      frame_check("f999", 7'h6F, 7'h6F, 7'h6F, 1'b0, 12'h000);

      // Reset in the middle of hundreds SHOW
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 4; c++) begin
            chk("prerst show", (3'b001 << d), 7'h6F, 1'b0);
            tick();
         end
         chk("prerst guard", 3'b000, 7'h00, 1'b0);
         tick();
      end
      chk("prerst hund c1", 3'b100, 7'h6F, 1'b0);
      tick();
      rst = 1'b1;
      chk("prerst hund c2", 3'b100, 7'h6F, 1'b0);
      tick();
      rst = 1'b0;
      frame_check("postrst", 7'h3F, 7'h00, 7'h00, 1'b0, 12'h000);
      blank_lz = 1'b0;
      frame_check("nolz000", 7'h3F, 7'h3F, 7'h3F, 1'b0, 12'h000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
